// File: rtl/vpu_writeback.sv
// Write-back stage: absorbs bias-stage results into a small FIFO and commits them to the
// Unified Buffer at base_addr + k*stride over a request/grant port.
module vpu_writeback #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned LVL_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [CNT_WIDTH-1:0]  num_elems,
    input  logic [DATA_WIDTH-1:0] wb_data_in,
    input  logic                  wb_valid_in,
    output logic                  ub_wr_req,
    output logic [ADDR_WIDTH-1:0] ub_wr_addr,
    output logic [DATA_WIDTH-1:0] ub_wr_data,
    input  logic                  ub_wr_gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err,
    output logic [LVL_W-1:0]      fifo_level
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  rx_cnt_q;
    logic [CNT_WIDTH-1:0]  wr_cnt_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic full, push, pop, push_ok, drop, last_commit;

    always_comb begin
        full        = (fifo_level == LVL_W'(FIFO_DEPTH));
        ub_wr_req   = (state_q == StRun) && (fifo_level != '0);
        pop         = ub_wr_req && ub_wr_gnt;
        push        = (state_q == StRun) && wb_valid_in && (rx_cnt_q < num_q);
        // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
        push_ok     = push && (!full || pop);
        drop        = push && full && !pop;
        last_commit = pop && (wr_cnt_q == num_q - CNT_WIDTH'(1));
    end

    assign ub_wr_addr = cur_addr_q;
    assign ub_wr_data = mem_q[rd_ptr_q];
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            stride_q     <= '0;
            num_q        <= '0;
            rx_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_level   <= '0;
            overflow_err <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wb_data_in;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                cur_addr_q <= cur_addr_q + stride_q;
                wr_cnt_q   <= wr_cnt_q + CNT_WIDTH'(1);
            end
            if (push) rx_cnt_q <= rx_cnt_q + CNT_WIDTH'(1);
            if (drop) overflow_err <= 1'b1;
            fifo_level <= fifo_level + LVL_W'(push_ok) - LVL_W'(pop);

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cur_addr_q   <= base_addr;
                        stride_q     <= stride;
                        num_q        <= num_elems;
                        rx_cnt_q     <= '0;
                        wr_cnt_q     <= '0;
                        wr_ptr_q     <= '0;
                        rd_ptr_q     <= '0;
                        fifo_level   <= '0;
                        overflow_err <= 1'b0;
                        state_q      <= (num_elems == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (last_commit) state_q <= StDone;
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
